// File: rtl/qdma_host_bridge_if.sv
// -----------------------------------------------------------------------------
// qdma_host_bridge_if
//   Groups the signals around the DMA host bridge: the initiator-side DMA
//   handshake, the host-memory wishbone master port and the NXM report.
//
//   Modports:
//     master : the bridge's view. It answers the DMA initiator and acts as
//              master on the host wishbone.
//     slave  : the environment's view (DMA initiator, host memory, CPU busy).
//
//   Signals:
//     cpu_busy_i            host CPU bus cycle in progress
//     dma_req_i / dma_gnt_o DMA bus request / grant
//     dma_adr_i[21:0]       transfer address from the initiator
//     dma_dat_i[15:0]       write data from the initiator
//     dma_dat_o[15:0]       read data returned to the initiator
//     dma_stb_i / dma_ack_o transfer strobe / acknowledge
//     dma_we_i              1 = write host memory, 0 = read
//     wbm_*                 host memory wishbone master signals
//     nxm_o / nxm_adr_o     non-existent-memory pulse and its address
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface qdma_host_bridge_if;
    logic        cpu_busy_i;
    logic        dma_req_i;
    logic        dma_gnt_o;
    logic [21:0] dma_adr_i;
    logic [15:0] dma_dat_i;
    logic [15:0] dma_dat_o;
    logic        dma_stb_i;
    logic        dma_we_i;
    logic        dma_ack_o;
    logic [21:0] wbm_adr_o;
    logic [15:0] wbm_dat_o;
    logic [15:0] wbm_dat_i;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [1:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic        nxm_o;
    logic [21:0] nxm_adr_o;

    modport master (
        input  cpu_busy_i, dma_req_i, dma_adr_i, dma_dat_i, dma_stb_i, dma_we_i,
               wbm_dat_i, wbm_ack_i,
        output dma_gnt_o, dma_dat_o, dma_ack_o,
               wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
               nxm_o, nxm_adr_o
    );

    modport slave (
        output cpu_busy_i, dma_req_i, dma_adr_i, dma_dat_i, dma_stb_i, dma_we_i,
               wbm_dat_i, wbm_ack_i,
        input  dma_gnt_o, dma_dat_o, dma_ack_o,
               wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
               nxm_o, nxm_adr_o
    );
endinterface

// File: rtl/qdma_host_bridge.sv
// -----------------------------------------------------------------------------
// qdma_host_bridge
//   Host-side responder for the peripheral DMA initiator. Grants the DMA bus
//   only while the host CPU bus is idle, runs each DMA word transfer as one
//   host wishbone cycle, returns ack/data to the initiator and flags
//   non-existent memory (NXM) when the host never acknowledges.
//
//   Ports:
//     lwb_clkp  clock, all logic on the rising edge
//     wb_rst_i  asynchronous, active-high reset
//     bus       qdma_host_bridge_if.master (DMA handshake, host wishbone, NXM)
//
//   Parameters:
//     TMO_CYCLES  host cycles without wbm_ack_i before NXM abort (>= 2)
//     MAX_BURST   transfers per grant before forced release (BURST_LIMIT_EN)
//     FAIR_GAP    cycles grant is held low after a forced release (BURST_LIMIT_EN)
//
//   Optional feature macro: BURST_LIMIT_EN
//     Defined   : grant is dropped after MAX_BURST transfers and not re-issued
//                 for FAIR_GAP cycles.
//     Undefined : grant is held as long as dma_req_i stays asserted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module qdma_host_bridge #(
    parameter int TMO_CYCLES = 64,
    parameter int MAX_BURST  = 8,
    parameter int FAIR_GAP   = 4
) (
    input  logic                 lwb_clkp,
    input  logic                 wb_rst_i,
    qdma_host_bridge_if.master   bus
);

    if (TMO_CYCLES < 2 || MAX_BURST < 1 || FAIR_GAP < 1) begin : g_bad_cfg
        $error("qdma_host_bridge: TMO_CYCLES >= 2, MAX_BURST >= 1, FAIR_GAP >= 1 required");
    end

    localparam int TW = $clog2(TMO_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITBUS,
        S_GRANT,
        S_XFER,
        S_ACK
    } state_t;

    state_t        state, state_nxt;
    logic          xfer_start;   // GRANT accepts a strobe this cycle
    logic          xfer_ack;     // host acknowledged during XFER
    logic          tmo_hit;      // XFER times out this cycle (ack has priority)
    logic          ack_exit;     // initiator released its strobe during ACK
    logic          burst_hit;    // this ACK exit completes the allowed burst
    logic          gap_ok;       // fairness gap has elapsed

    logic [TW-1:0] tmo_cnt;
    logic [21:0]   adr_q;
    logic [15:0]   dat_q;
    logic          we_q;
    logic [15:0]   rdata_q;
    logic          nxm_q;
    logic [21:0]   nxm_adr_q;

    assign xfer_ack = (state == S_XFER) && bus.wbm_ack_i;
    assign tmo_hit  = (state == S_XFER) && !bus.wbm_ack_i && (tmo_cnt == TMO_LAST);
    assign ack_exit = (state == S_ACK) && !bus.dma_stb_i;

    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        xfer_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dma_req_i) state_nxt = S_WAITBUS;
            end
            S_WAITBUS: begin
                if (!bus.dma_req_i)                      state_nxt = S_IDLE;
                else if (!bus.cpu_busy_i && gap_ok)      state_nxt = S_GRANT;
            end
            S_GRANT: begin
                // A strobe wins even if the request drops in the same cycle.
                if (bus.dma_stb_i) begin
                    state_nxt  = S_XFER;
                    xfer_start = 1'b1;
                end else if (!bus.dma_req_i) begin
                    state_nxt  = S_IDLE;
                end
            end
            S_XFER: begin
                if (xfer_ack || tmo_hit) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (ack_exit) begin
                    if (!bus.dma_req_i)  state_nxt = S_IDLE;
                    else if (burst_hit)  state_nxt = S_WAITBUS;
                    else                 state_nxt = S_GRANT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order. The reset is asynchronous
    // so the host cycle and the ack drop the moment wb_rst_i rises.
    always_ff @(posedge lwb_clkp or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            nxm_q     <= 1'b0;
            nxm_adr_q <= '0;
        end else begin
            state <= state_nxt;
            nxm_q <= tmo_hit;

            if (xfer_start) begin
                adr_q   <= bus.dma_adr_i;
                dat_q   <= bus.dma_dat_i;
                we_q    <= bus.dma_we_i;
                tmo_cnt <= '0;
            end else if (state == S_XFER) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            // Read data is held for the initiator until the next read or abort.
            if (xfer_ack && !we_q) begin
                rdata_q <= bus.wbm_dat_i;
            end else if (tmo_hit) begin
                rdata_q   <= '0;
                nxm_adr_q <= adr_q;
            end
        end
    end

`ifdef BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(FAIR_GAP + 1);

    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] gap_cnt;
    logic          gnt_nxt;

    assign gnt_nxt   = (state_nxt == S_GRANT) || (state_nxt == S_XFER) || (state_nxt == S_ACK);
    assign burst_hit = (burst_cnt == BW'(MAX_BURST - 1));
    assign gap_ok    = (gap_cnt == '0);

    always_ff @(posedge lwb_clkp or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if (!gnt_nxt)      burst_cnt <= '0;
            else if (ack_exit) burst_cnt <= burst_cnt + BW'(1);

            // Loaded with FAIR_GAP-1: the WAITBUS cycle that sees zero is itself
            // the last low-grant cycle, giving exactly FAIR_GAP cycles.
            if (ack_exit && bus.dma_req_i && burst_hit) gap_cnt <= GW'(FAIR_GAP - 1);
            else if (gap_cnt != '0)                     gap_cnt <= gap_cnt - GW'(1);
        end
    end
`else
    assign burst_hit = 1'b0;
    assign gap_ok    = 1'b1;
`endif

    assign bus.dma_gnt_o = (state == S_GRANT) || (state == S_XFER) || (state == S_ACK);
    assign bus.dma_ack_o = (state == S_ACK);
    assign bus.dma_dat_o = rdata_q;
    assign bus.wbm_cyc_o = (state == S_XFER);
    assign bus.wbm_stb_o = (state == S_XFER);
    assign bus.wbm_we_o  = (state == S_XFER) && we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = 2'b11;    // word transfers only
    assign bus.nxm_o     = nxm_q;
    assign bus.nxm_adr_o = nxm_adr_q;

endmodule

// File: tb/tb_qdma_host_bridge.sv
// -----------------------------------------------------------------------------
// tb_qdma_host_bridge
//   Self-checking bench for qdma_host_bridge: directed vector table, hand-written
//   reset / ignored-strobe / burst sequences, then randomized sessions checked
//   against a transaction-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_qdma_host_bridge;

    localparam int TMO = 64;
    localparam int MB  = 8;
    localparam int FG  = 4;

    logic lwb_clkp = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 lwb_clkp = ~lwb_clkp;

    qdma_host_bridge_if bus();

    qdma_host_bridge #(.TMO_CYCLES(TMO), .MAX_BURST(MB), .FAIR_GAP(FG)) dut (
        .lwb_clkp (lwb_clkp),
        .wb_rst_i (wb_rst_i),
        .bus      (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the initiator should see on dma_dat_o and
    // nxm_adr_o after the most recent completed transfer.
    logic [15:0] m_dat     = '0;
    logic [21:0] m_nxm_adr = '0;

    typedef struct {
        logic [21:0] adr;
        logic [15:0] dat;
        bit          we;
        int          lat;       // ack issued in this XFER cycle (0-based)
        logic [15:0] rdata;
        int          busy;      // CPU busy cycles before grant
        logic [15:0] exp_dat;
        bit          exp_nxm;
        logic [21:0] exp_nxm_adr;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge lwb_clkp);
        #1;
    endtask

    // Requires state IDLE. Holds the CPU busy for 'busy' cycles, then waits
    // for the grant and checks its latency.
    task automatic acquire(input int busy);
        int low;
        int w;
        low = 0;
        bus.dma_req_i  = 1'b1;
        bus.cpu_busy_i = (busy > 0);
        repeat (busy) begin
            tick();
            if (!bus.dma_gnt_o) low++;
        end
        if (busy > 0) check("gnt_blocked_by_cpu", low, busy);
        bus.cpu_busy_i = 1'b0;
        w = 0;
        while (!bus.dma_gnt_o && w < 10) begin
            tick();
            w++;
        end
        check("gnt_latency", w, (busy > 0) ? 1 : 2);
    endtask

    task automatic release_gnt();
        bus.dma_req_i = 1'b0;
        tick();
        check("gnt_release", bus.dma_gnt_o, 0);
    endtask

    // Requires state GRANT. Runs one transfer acting as host memory.
    task automatic do_xfer(input logic [21:0] adr, input logic [15:0] dat, input bit we,
                           input int lat, input logic [15:0] rdata,
                           input logic [15:0] exp_dat, input bit exp_nxm,
                           input logic [21:0] exp_nxm_adr,
                           input bit drop_req, input bit exp_gnt);
        int          n;
        int          hold;
        int          n_ack;
        int          n_nxm;
        logic [21:0] a_adr;
        logic        a_we;
        logic [15:0] a_dat;
        logic [1:0]  a_sel;

        bus.dma_adr_i = adr;
        bus.dma_dat_i = dat;
        bus.dma_we_i  = we;
        bus.wbm_dat_i = rdata;
        bus.dma_stb_i = 1'b1;
        tick();
        check("stb_to_wbm_stb", bus.wbm_stb_o, 1);
        a_adr = bus.wbm_adr_o;
        a_we  = bus.wbm_we_o;
        a_dat = bus.wbm_dat_o;
        a_sel = bus.wbm_sel_o;
        n = 0;
        while (bus.wbm_cyc_o && n < 200) begin
            bus.wbm_ack_i  = (n == lat);
            bus.cpu_busy_i = 1'($urandom_range(0, 1));
            if (drop_req) bus.dma_req_i = 1'b0;
            n++;
            tick();
        end
        bus.wbm_ack_i = 1'b0;

        check("xfer_cycles", n, exp_nxm ? TMO : lat + 1);
        check("wbm_adr", a_adr, adr);
        check("wbm_we", a_we, we);
        if (we) check("wbm_dat", a_dat, dat);
        check("wbm_sel", a_sel, 2'b11);
        check("dma_ack_after_host", bus.dma_ack_o, 1);
        check("nxm_pulse", bus.nxm_o, exp_nxm);
        check("nxm_adr", bus.nxm_adr_o, exp_nxm_adr);
        check("dma_dat", bus.dma_dat_o, exp_dat);

        hold  = $urandom_range(1, 3);
        n_ack = 0;
        n_nxm = 0;
        repeat (hold) begin
            tick();
            if (bus.dma_ack_o) n_ack++;
            if (bus.nxm_o)     n_nxm++;
        end
        check("ack_held_while_stb", n_ack, hold);
        check("nxm_single_cycle", n_nxm, 0);

        bus.cpu_busy_i = 1'b0;
        bus.dma_stb_i  = 1'b0;
        tick();
        check("ack_drop", bus.dma_ack_o, 0);
        check("gnt_after_xfer", bus.dma_gnt_o, exp_gnt);
    endtask

    // Runs a transfer with expectations taken from the reference model.
    task automatic model_xfer(input logic [21:0] adr, input logic [15:0] dat, input bit we,
                              input int lat, input logic [15:0] rdata,
                              input bit drop_req, input bit exp_gnt);
        bit nxm;
        nxm = (lat >= TMO);
        if (nxm) begin
            m_dat     = '0;
            m_nxm_adr = adr;
        end else if (!we) begin
            m_dat = rdata;
        end
        do_xfer(adr, dat, we, lat, rdata, m_dat, nxm, m_nxm_adr, drop_req, exp_gnt);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cpu_busy_i = 1'b0;
        bus.dma_req_i  = 1'b0;
        bus.dma_adr_i  = '0;
        bus.dma_dat_i  = '0;
        bus.dma_stb_i  = 1'b0;
        bus.dma_we_i   = 1'b0;
        bus.wbm_dat_i  = '0;
        bus.wbm_ack_i  = 1'b0;

        vt[0] = '{22'o001000,   16'o000000, 1'b0, 3,    16'o123456, 0,  16'o123456, 1'b0, 22'o0};
        vt[1] = '{22'o017776,   16'o000777, 1'b1, 2,    16'o111111, 10, 16'o123456, 1'b0, 22'o0};
        vt[2] = '{22'o17777776, 16'o000000, 1'b0, 1000, 16'o070707, 0,  16'o000000, 1'b1, 22'o17777776};
        vt[3] = '{22'o000100,   16'o000000, 1'b0, 63,   16'o055555, 2,  16'o055555, 1'b0, 22'o17777776};
        vt[4] = '{22'o000200,   16'o177777, 1'b1, 64,   16'o044444, 0,  16'o000000, 1'b1, 22'o000200};

        // Reset state
        repeat (3) tick();
        check("rst_ctrl", {bus.dma_gnt_o, bus.dma_ack_o, bus.wbm_cyc_o, bus.wbm_stb_o,
                           bus.wbm_we_o, bus.nxm_o}, 0);
        check("rst_dma_dat", bus.dma_dat_o, 0);
        check("rst_wbm_adr", bus.wbm_adr_o, 0);
        check("rst_nxm_adr", bus.nxm_adr_o, 0);
        wb_rst_i = 1'b0;
        tick();

        // Strobe without a grant is ignored
        begin
            int seen;
            seen = 0;
            bus.dma_stb_i = 1'b1;
            repeat (3) begin
                tick();
                if (bus.wbm_cyc_o || bus.dma_gnt_o) seen++;
            end
            bus.dma_stb_i = 1'b0;
            tick();
            check("stb_without_gnt", seen, 0);
        end

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            acquire(vt[i].busy);
            do_xfer(vt[i].adr, vt[i].dat, vt[i].we, vt[i].lat, vt[i].rdata,
                    vt[i].exp_dat, vt[i].exp_nxm, vt[i].exp_nxm_adr, 1'b0, 1'b1);
            release_gnt();
            m_dat     = vt[i].exp_dat;
            m_nxm_adr = vt[i].exp_nxm_adr;
        end

        // Request dropped mid-transfer: completes, then grant goes low
        acquire(0);
        model_xfer(22'o004000, 16'o0, 1'b0, 2, 16'o012345, 1'b1, 1'b0);

        // Reset asserted mid-XFER
        acquire(0);
        bus.dma_adr_i = 22'o002000;
        bus.dma_we_i  = 1'b0;
        bus.dma_stb_i = 1'b1;
        repeat (3) tick();
        check("mid_xfer_cyc", bus.wbm_cyc_o, 1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("async_rst_ctrl", {bus.dma_gnt_o, bus.dma_ack_o, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        bus.dma_stb_i = 1'b0;
        bus.dma_req_i = 1'b0;
        tick();
        wb_rst_i = 1'b0;
        tick();
        check("idle_after_rst", {bus.dma_gnt_o, bus.wbm_cyc_o, bus.dma_ack_o}, 0);
        m_dat     = '0;
        m_nxm_adr = '0;

`ifdef BURST_LIMIT_EN
        // Burst limit: grant drops after MB transfers for FG cycles
        begin
            int low;
            acquire(0);
            for (int j = 0; j < 10; j++) begin
                model_xfer(22'(j * 2), 16'o0, 1'b0, 1, 16'(16'o100 + j), 1'b0, (j != MB - 1));
                if (j == MB - 1) begin
                    low = 1;
                    while (!bus.dma_gnt_o && low < 30) begin
                        tick();
                        if (!bus.dma_gnt_o) low++;
                    end
                    check("fair_gap_low_cycles", low, FG);
                end
            end
            release_gnt();
        end
`endif

        // Randomized sessions against the reference model
        for (int s = 0; s < 25; s++) begin
            int k;
            acquire($urandom_range(0, 3));
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                logic [21:0] adr;
                logic [15:0] dat;
                logic [15:0] rdata;
                bit          we;
                bit          drop;
                int          lat;
                adr   = 22'($urandom);
                dat   = 16'($urandom);
                rdata = 16'($urandom);
                we    = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 9))
                    0:       lat = $urandom_range(TMO, TMO + 6);
                    1:       lat = TMO - 1;
                    default: lat = $urandom_range(0, 6);
                endcase
                drop = (j == k - 1) && ($urandom_range(0, 1) == 1);
                model_xfer(adr, dat, we, lat, rdata, drop, !drop);
                if ((j == k - 1) && !drop) release_gnt();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
